cmp_seq_unit: RTL and testbench

Parametrised multi-cycle magnitude comparator for the ALU set-on-compare path (SLT/SLTU/SEQ/SGT).
- Latches two operands on START and scans them MSB-first, CHUNK bits per cycle.
- Terminates early at the first differing chunk.
- Returns LT/EQ/GT flags plus a zero-extended MIPS-style 0/1 RESULT with a START/DONE handshake.
- Signed and unsigned modes are supported.

---
 rtl/cmp_seq_unit.sv | 92 +++++++++
 tb/tb_cmp_seq_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq_unit.sv
// cmp_seq_unit: multi-cycle MSB-first chunked magnitude comparator for SLT/SLTU/SEQ/SGT.
module cmp_seq_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] result_o,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0] mode_q, mode_d;
  logic [IW-1:0] idx_q, idx_d;
  logic lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, res_q, res_d;
  logic [CHUNK-1:0] ca, cb;
  assign ca = a_q[idx_q*CHUNK +: CHUNK];
  assign cb = b_q[idx_q*CHUNK +: CHUNK];
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    mode_d = mode_q;
    idx_d = idx_q;
    lt_d = lt_q;
    eq_d = eq_q;
    gt_d = gt_q;
    res_d = res_q;
    if (state_q == RUN) begin
      if (ca != cb || idx_q == '0) begin
        state_d = DONE;
        lt_d = ca < cb;
        eq_d = ca == cb;
        gt_d = ca > cb;
        res_d = mode_q == 2'b10 ? (ca == cb) : mode_q == 2'b11 ? (ca > cb) : (ca < cb);
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end else if (start_i) begin
      // signed modes flip the sign bit so an unsigned scan orders two's complement values
      state_d = RUN;
      a_d = mode_i[0] ? rs_i ^ MSB : rs_i;
      b_d = mode_i[0] ? rt_i ^ MSB : rt_i;
      mode_d = mode_i;
      idx_d = IW'(NCH - 1);
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      mode_q <= '0;
      idx_q <= '0;
      lt_q <= 1'b0;
      eq_q <= 1'b0;
      gt_q <= 1'b0;
      res_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      mode_q <= mode_d;
      idx_q <= idx_d;
      lt_q <= lt_d;
      eq_q <= eq_d;
      gt_q <= gt_d;
      res_q <= res_d;
    end
  end
  assign busy_o = state_q == RUN;
  assign done_o = state_q == DONE;
  assign result_o = {{(OUT_W-1){1'b0}}, res_q};
  assign lt_o = lt_q;
  assign eq_o = eq_q;
  assign gt_o = gt_q;
endmodule

// File: tb/tb_cmp_seq_unit.sv
// tb_cmp_seq_unit: random and directed checks of cmp_seq_unit at three WIDTH/CHUNK settings.
module tb_cmp_seq_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = '0;
  logic [2:0][1:0] mode = '0;
  logic [2:0][31:0] rs = '0;
  logic [2:0][31:0] rt = '0;
  logic [2:0] busy, done, lt, eq, gt;
  logic [2:0][15:0] res;
  int checks = 0;
  int errors = 0;
  int ww[3] = '{16, 32, 8};
  int cc[3] = '{4, 8, 1};
  always #5 clk = ~clk;
  cmp_seq_unit #(.WIDTH(16), .CHUNK(4), .OUT_W(16)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .mode_i(mode[0]), .rs_i(rs[0][15:0]), .rt_i(rt[0][15:0]),
    .busy_o(busy[0]), .done_o(done[0]), .result_o(res[0]), .lt_o(lt[0]), .eq_o(eq[0]), .gt_o(gt[0]));
  cmp_seq_unit #(.WIDTH(32), .CHUNK(8), .OUT_W(16)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .mode_i(mode[1]), .rs_i(rs[1]), .rt_i(rt[1]),
    .busy_o(busy[1]), .done_o(done[1]), .result_o(res[1]), .lt_o(lt[1]), .eq_o(eq[1]), .gt_o(gt[1]));
  cmp_seq_unit #(.WIDTH(8), .CHUNK(1), .OUT_W(16)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .mode_i(mode[2]), .rs_i(rs[2][7:0]), .rt_i(rt[2][7:0]),
    .busy_o(busy[2]), .done_o(done[2]), .result_o(res[2]), .lt_o(lt[2]), .eq_o(eq[2]), .gt_o(gt[2]));
  function automatic void model(input int w, input int c, input logic [1:0] m, input longint a, input longint b,
                                output logic elt, output logic eeq, output logic egt, output logic eres, output int k);
    longint sa = a, sb = b;
    int n = w / c;
    if (m[0]) begin
      if (a >= (64'sd1 <<< (w - 1))) sa = a - (64'sd1 <<< w);
      if (b >= (64'sd1 <<< (w - 1))) sb = b - (64'sd1 <<< w);
    end
    elt = sa < sb;
    eeq = sa == sb;
    egt = sa > sb;
    eres = m == 2'b10 ? eeq : m == 2'b11 ? egt : elt;
    k = n;
    for (int i = 0; i < n; i++)
      if (((a >>> (i * c)) & ((64'sd1 <<< c) - 1)) != ((b >>> (i * c)) & ((64'sd1 <<< c) - 1))) k = n - i;
  endfunction
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic run_op(input int d, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b, input string nm);
    logic elt, eeq, egt, eres;
    int k, lat;
    model(ww[d], cc[d], m, longint'(a), longint'(b), elt, eeq, egt, eres, k);
    mode[d] = m;
    rs[d] = a;
    rt[d] = b;
    start[d] = 1'b1;
    tick(1);
    start[d] = 1'b0;
    checks++;
    if (busy[d] !== 1'b1 || done[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s first cycle busy=%b done=%b want busy=1 done=0", nm, busy[d], done[d]);
    end
    lat = 1;
    while (done[d] !== 1'b1 && lat < 40) begin
      tick(1);
      lat++;
    end
    checks++;
    if (lat != k + 1) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d (d=%0d m=%0d a=%h b=%h)", nm, lat, k + 1, d, m, a, b);
    end
    checks++;
    if ({lt[d], eq[d], gt[d], res[d]} !== {elt, eeq, egt, 15'd0, eres}) begin
      errors++;
      $display("FAIL %s flags lt/eq/gt/res got %b%b%b/%h want %b%b%b/%h (d=%0d m=%0d a=%h b=%h)",
               nm, lt[d], eq[d], gt[d], res[d], elt, eeq, egt, {15'd0, eres}, d, m, a, b);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({busy, done, lt, eq, gt, res} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got busy=%b done=%b lt=%b eq=%b gt=%b res=%h want all 0",
                 i, busy, done, lt, eq, gt, res);
      end
      tick(1);
    end
  endtask
  task automatic test_directed();
    run_op(0, 2'b00, 32'h0001, 32'h8000, "sltu_early");
    tick(1);
    checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0 || res[0] !== 16'h0001 || lt[0] !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse_hold got done=%b busy=%b res=%h lt=%b want 0 0 0001 1", done[0], busy[0], res[0], lt[0]);
    end
    run_op(0, 2'b01, 32'h0001, 32'h8000, "slt_early");
    tick(1);
    run_op(0, 2'b01, 32'hFFF0, 32'hFFF1, "slt_full");
    tick(1);
    run_op(0, 2'b10, 32'h1234, 32'h1234, "seq_equal");
    tick(1);
    run_op(0, 2'b11, 32'h7FFF, 32'h8000, "sgt_early");
    tick(1);
  endtask
  task automatic test_start_while_busy();
    int lat, ndone;
    mode[0] = 2'b01;
    rs[0] = 32'hFFF0;
    rt[0] = 32'hFFF1;
    start[0] = 1'b1;
    tick(1);
    mode[0] = 2'b11;
    rs[0] = 32'h0000;
    rt[0] = 32'h8000;
    tick(1);
    start[0] = 1'b0;
    lat = 2;
    while (done[0] !== 1'b1 && lat < 40) begin
      tick(1);
      lat++;
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL busy_start latency got %0d want 5", lat);
    end
    checks++;
    if ({lt[0], eq[0], gt[0], res[0]} !== {3'b100, 16'h0001}) begin
      errors++;
      $display("FAIL busy_start flags got %b%b%b/%h want 100/0001", lt[0], eq[0], gt[0], res[0]);
    end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (done[0] === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL busy_start extra done count got %0d busy=%b want 0 0", ndone, busy[0]);
    end
  endtask
  task automatic test_back_to_back();
    run_op(0, 2'b00, 32'h0001, 32'h8000, "b2b_first");
    run_op(0, 2'b10, 32'h1234, 32'h1235, "b2b_second");
    run_op(0, 2'b11, 32'hFFFF, 32'h0000, "b2b_third");
    tick(1);
  endtask
  task automatic test_reset_mid();
    int ndone;
    mode[0] = 2'b01;
    rs[0] = 32'hFFF0;
    rt[0] = 32'hFFF1;
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({busy[0], done[0], lt[0], eq[0], gt[0], res[0]} !== '0) begin
      errors++;
      $display("FAIL reset_mid state got busy=%b done=%b lt=%b eq=%b gt=%b res=%h want all 0",
               busy[0], done[0], lt[0], eq[0], gt[0], res[0]);
    end
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (done[0] === 1'b1 || busy[0] === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL reset_mid activity cycles got %0d want 0", ndone);
    end
  endtask
  task automatic test_random();
    logic [31:0] msk, a, b;
    for (int d = 0; d < 3; d++) begin
      msk = ww[d] == 32 ? 32'hFFFF_FFFF : (32'd1 << ww[d]) - 1;
      for (int m = 0; m < 4; m++)
        for (int n = 0; n < 300; n++) begin
          a = $urandom & msk;
          case ($urandom_range(3))
            0: b = $urandom & msk;
            1: b = a;
            default: b = (a ^ ($urandom & ((32'd1 << $urandom_range(ww[d] - 1)) - 1))) & msk;
          endcase
          run_op(d, m[1:0], a, b, "random");
          if ($urandom_range(1) == 1) tick(1);
        end
      tick(1);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
